// File: rtl/deserializer.sv
// LSB-first serial-to-parallel receiver: rebuilds DATA_W-bit words from the
// serializer bit stream and pushes them to the receive FIFO, with error status.
module deserializer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    input  logic              piso_start,
    input  logic              piso_done,
    input  logic              full,
    output logic              wr_fifo,
    output logic [DATA_W-1:0] wr_data,
    input  logic              err_clr,
    output logic              frame_err,
    output logic              ovf_err,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              wr_fifo_q, wr_fifo_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              frame_err_q, frame_err_d;
    logic              ovf_err_q, ovf_err_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              frame_ev, ovf_ev, word_ev, drop_ev;
    logic [DATA_W-1:0] sreg_shifted;

    assign sreg_shifted = {ser_in, sreg_q[DATA_W-1:1]};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        wr_fifo_d = 1'b0;
        wr_data_d = wr_data_q;
        frame_ev  = 1'b0;
        ovf_ev    = 1'b0;
        word_ev   = 1'b0;
        drop_ev   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (piso_start) begin
                    sreg_d    = sreg_shifted;
                    bit_cnt_d = BIT_W'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sreg_d = sreg_shifted;
                if (piso_start) begin
                    // Restart mid-word: the bit now on ser_in is bit 0 of a new frame.
                    frame_ev  = 1'b1;
                    drop_ev   = 1'b1;
                    bit_cnt_d = BIT_W'(1);
                end else if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = CHECK;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            CHECK: begin
                if (piso_done && !full) begin
                    wr_fifo_d = 1'b1;
                    wr_data_d = sreg_q;
                    word_ev   = 1'b1;
                end else if (piso_done) begin
                    ovf_ev  = 1'b1;
                    drop_ev = 1'b1;
                end else begin
                    frame_ev = 1'b1;
                    drop_ev  = 1'b1;
                end
                if (piso_start) begin
                    sreg_d    = sreg_shifted;
                    bit_cnt_d = BIT_W'(1);
                    state_d   = SHIFT;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A same-cycle event beats err_clr: clear first, then apply the event.
    always_comb begin
        frame_err_d = frame_ev | (frame_err_q & ~err_clr);
        ovf_err_d   = ovf_ev | (ovf_err_q & ~err_clr);
        word_cnt_d  = sat_inc(err_clr ? '0 : word_cnt_q, word_ev);
        drop_cnt_d  = sat_inc(err_clr ? '0 : drop_cnt_q, drop_ev);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            wr_fifo_q   <= 1'b0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            word_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            wr_fifo_q   <= wr_fifo_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            ovf_err_q   <= ovf_err_d;
            word_cnt_q  <= word_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign wr_fifo   = wr_fifo_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign ovf_err   = ovf_err_q;
    assign word_cnt  = word_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed frames plus randomized traffic,
// scored against a frame-level model of expected writes, flags and counters.
module tb_deserializer;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ser_in, piso_start, piso_done, full, err_clr;
    logic              wr_fifo;
    logic [DATA_W-1:0] wr_data;
    logic              frame_err, ovf_err;
    logic [CNT_W-1:0]  word_cnt, drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int word_m, drop_m;
    bit frame_m, ovf_m;

    deserializer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .piso_start(piso_start),
        .piso_done (piso_done),
        .full      (full),
        .wr_fifo   (wr_fifo),
        .wr_data   (wr_data),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .ovf_err   (ovf_err),
        .word_cnt  (word_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && wr_fifo) got_q.push_back(wr_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic clear_model();
        frame_m = 1'b0;
        ovf_m   = 1'b0;
        word_m  = 0;
        drop_m  = 0;
    endtask

    // One serializer frame: 8 data bits, then the done/check cycle, then idle gap.
    task automatic send_frame(input logic [7:0] w, input bit done, input bit full_chk,
                              input bit clr_chk, input int gap);
        for (int i = 0; i < DATA_W; i++) begin
            ser_in     = w[i];
            piso_start = (i == 0);
            tick();
        end
        ser_in     = 1'b0;
        piso_start = 1'b0;
        piso_done  = done;
        full       = full_chk;
        err_clr    = clr_chk;
        tick();
        err_clr = 1'b0;
        if (clr_chk) clear_model();
        if (done && !full_chk) begin
            exp_q.push_back(w);
            word_m = sat(word_m);
        end else if (done) begin
            ovf_m  = 1'b1;
            drop_m = sat(drop_m);
        end else begin
            frame_m = 1'b1;
            drop_m  = sat(drop_m);
        end
        for (int g = 0; g < gap; g++) begin
            piso_done = 1'($urandom_range(0, 1));
            full      = 1'($urandom_range(0, 1));
            tick();
        end
        piso_done = 1'b0;
        full      = 1'b0;
    endtask

    task automatic send_partial(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ser_in     = w[i];
            piso_start = (i == 0);
            tick();
        end
        ser_in     = 1'b0;
        piso_start = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        clear_model();
    endtask

    task automatic check_status(input string tag);
        tick();
        tick();
        chk({tag, "/word_cnt"}, 32'(word_cnt), 32'(word_m));
        chk({tag, "/drop_cnt"}, 32'(drop_cnt), 32'(drop_m));
        chk({tag, "/frame_err"}, 32'(frame_err), 32'(frame_m));
        chk({tag, "/ovf_err"}, 32'(ovf_err), 32'(ovf_m));
        chk({tag, "/num_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "/wr_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst        = 1'b1;
        ser_in     = 1'b0;
        piso_start = 1'b0;
        piso_done  = 1'b0;
        full       = 1'b0;
        err_clr    = 1'b0;
        clear_model();
        #1;
        chk("reset/outputs", 32'({wr_fifo, wr_data, frame_err, ovf_err, word_cnt, drop_cnt}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 0xA5: write must be visible exactly two cycles after the last bit.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
        chk("a5/wr_fifo_at_T+2", 32'(wr_fifo), 32'd1);
        chk("a5/wr_data_at_T+2", 32'(wr_data), 32'hA5);
        tick();
        chk("a5/wr_fifo_one_cycle", 32'(wr_fifo), 32'd0);
        chk("a5/wr_data_held", 32'(wr_data), 32'hA5);
        check_status("a5");

        // Back to back at minimum spacing.
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1);
        send_frame(8'h80, 1'b1, 1'b0, 1'b0, 1);
        check_status("b2b");

        // Overflow then normal write.
        clear_errors();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1);
        check_status("ovf");

        // Done withheld.
        clear_errors();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 2);
        check_status("no_done");

        // Restart at bit 4, then a full 0x96 frame.
        clear_errors();
        send_partial(8'hE7, 4);
        frame_m = 1'b1;
        drop_m  = sat(drop_m);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1);
        check_status("restart");

        // Reset at bit 3, then a 0xC3 frame.
        send_partial(8'h7E, 3);
        rst = 1'b1;
        #1;
        chk("midrst/outputs", 32'({wr_fifo, wr_data, frame_err, ovf_err, word_cnt, drop_cnt}), 32'd0);
        tick();
        tick();
        chk("midrst/outputs_held", 32'({wr_fifo, wr_data, frame_err, ovf_err, word_cnt, drop_cnt}), 32'd0);
        rst = 1'b0;
        clear_model();
        exp_q.delete();
        got_q.delete();
        tick();
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1);
        check_status("midrst");

        // err_clr with both flags set and drop_cnt=2, then err_clr coincident with overflow.
        clear_errors();
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1);
        check_status("pre_clr");
        clear_errors();
        check_status("clr");
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1);
        send_frame(8'h44, 1'b1, 1'b1, 1'b1, 1);
        check_status("clr_vs_ovf");

        // Randomized traffic mixing good frames, overflow, missing done and restarts.
        clear_errors();
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 3) begin
                send_partial(8'($urandom), $urandom_range(1, DATA_W - 1));
                frame_m = 1'b1;
                drop_m  = sat(drop_m);
            end
            send_frame(8'($urandom), r != 0, (r == 1) || (r == 2), 1'b0, $urandom_range(0, 2));
        end
        check_status("random");

        // Counter saturation.
        clear_errors();
        for (int n = 0; n < 260; n++)
            send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 0);
        check_status("saturate");
        chk("saturate/word_cnt_max", 32'(word_cnt), 32'(CMAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Serial-to-parallel (SIPO) stage directly downstream of the PLC serializer.
- Consumes the serializer's LSB-first bit stream (ser_out) plus its piso_start and piso_done framing strobes, reassembles DATA_W-bit words, and pushes them into the receive FIFO.
- Detects framing errors (missing done, restart mid-word) and FIFO overflow; keeps sticky flags and saturating counters for status readout.

Parameters:
- DATA_W, 8, word width in bits; must match the serializer word size.
- CNT_W, 8, width of each status counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ser_in  input  1  serial data, LSB first (from ser_out)
- piso_start  input  1  high in the cycle that bit 0 is on ser_in
- piso_done  input  1  high in the cycle after the last bit
- full  input  1  receive FIFO full
- wr_fifo  output  1  one-cycle FIFO write strobe
- wr_data  output  DATA_W  assembled word
- err_clr  input  1  synchronous clear of sticky flags and counters
- frame_err  output  1  sticky framing-error flag
- ovf_err  output  1  sticky overflow flag
- word_cnt  output  CNT_W  words written, saturating
- drop_cnt  output  CNT_W  words discarded (framing error or overflow), saturating

Behaviour:
- Reset: the block is asynchronous and active-high. While rst is high: state=IDLE, shift register=0, bit counter=0, wr_fifo=0, wr_data=0, frame_err=0, ovf_err=0, word_cnt=0, drop_cnt=0.
- All outputs are registered.
- Shift rule: on each sampled bit, sreg <= {ser_in, sreg[DATA_W-1:1]}. After DATA_W bits, bit 0 is in the LSB.
- IDLE:
  - piso_start=1: sample ser_in as bit 0, bit counter <= 1, go to SHIFT.
  - Otherwise stay in IDLE.
  - piso_done seen in IDLE is ignored.
- SHIFT:
  - Sample ser_in every cycle and increment the bit counter.
  - The cycle that samples bit DATA_W-1 goes to CHECK.
  - piso_start=1 in SHIFT: set frame_err, increment drop_cnt, discard the partial word. Treat the current bit as bit 0 of a new frame (bit counter <= 1) and stay in SHIFT.
- CHECK (one cycle, the cycle after the last bit):
  - piso_done=1 and full=0: next cycle wr_fifo=1, wr_data=sreg, word_cnt+1.
  - piso_done=1 and full=1: drop the word, set ovf_err, drop_cnt+1, wr_fifo stays 0.
  - piso_done=0: set frame_err, drop_cnt+1, no write.
  - Exit: go to IDLE. If piso_start=1 in the same cycle, first resolve the CHECK outcome as above, then sample bit 0 and go to SHIFT.
- Latency: last data bit at cycle T, piso_done sampled at T+1, wr_fifo high at T+2 for exactly one cycle.
- wr_data holds its value until the next write.
- Counters saturate at 2^CNT_W-1.
- err_clr:
  - Zeroes frame_err, ovf_err, word_cnt and drop_cnt on the next edge.
  - An error or count event in the same cycle as err_clr wins: the flag is set and the counter is 1.
  - err_clr does not affect the datapath or state.
- Reset asserted mid-frame: the partial word is lost and there is no write. The next frame is accepted only on a fresh piso_start.
- Back-to-back frames at serializer rate (start two cycles after done) are received without loss.

Test Plan:
- 0xA5 sent LSB first (1,0,1,0,0,1,0,1) with start on bit 0 and done one cycle after bit 7, full=0 -> wr_fifo pulses once at T+2 with wr_data=0xA5, word_cnt=1, no error flags.
- Frames 0x01, 0xFF, 0x80 sent back to back at minimum spacing -> three writes in order with those values, word_cnt=3, drop_cnt=0.
- Frame 0x3C with full=1 in the CHECK cycle -> no wr_fifo, ovf_err=1, drop_cnt=1. A following 0x55 with full=0 is written normally.
- Frame with done withheld -> frame_err=1, drop_cnt=1, no write. Second case: start re-asserted at bit 4, then a full 0x96 frame follows -> frame_err=1, drop_cnt=1, then 0x96 written.
- rst pulsed at bit 3, then a 0xC3 frame -> all outputs 0 during reset, then exactly one write of 0xC3.
- err_clr pulsed with frame_err=1, ovf_err=1, drop_cnt=2 -> all cleared. err_clr coincident with an overflow -> ovf_err=1, drop_cnt=1. Pushing 260 words with CNT_W=8 -> word_cnt holds at 255.
